// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / DMA) arbiter in front of memory port 2.
// Accepts one access at a time, round-robins on ties, and returns read data
// to the owning requester after RD_LAT cycles, with a one-cycle rvalid pulse.
module dmem_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        ARB_clk,
    input  logic        ARB_RST_n,
    // CPU requester
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    // DMA requester
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_size,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    // Memory port 2
    output logic        mem_RDEN2,
    output logic        mem_WE2,
    output logic [31:0] mem_addr2,
    output logic [31:0] mem_din2,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_dout2,
    output logic        busy
);

    // Handshake: a requester raises req with stable fields and holds them until
    // it sees gnt (asserted for the single ISSUE cycle). Once latched in IDLE the
    // access completes even if req falls. rvalid pulses once, the cycle after
    // the read data has been captured into that requester's rdata register.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic        win_dma_q, win_dma_d;     // owner of the current access
    logic        last_dma_q, last_dma_d;   // last grant went to DMA
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;
    logic        cpu_rvalid_q, cpu_rvalid_d;
    logic        dma_rvalid_q, dma_rvalid_d;
    logic        pick_dma;

    // Next-state, arbitration, field latching and read-data capture
    always_comb begin
        state_d      = state_q;
        win_dma_d    = win_dma_q;
        last_dma_d   = last_dma_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        cnt_d        = cnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        cpu_rvalid_d = 1'b0;
        dma_rvalid_d = 1'b0;
        // On a tie the requester that did not win last time gets the port
        pick_dma     = dma_req && (!cpu_req || !last_dma_q);
        unique case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    win_dma_d  = pick_dma;
                    last_dma_d = pick_dma;
                    we_d       = pick_dma ? dma_we    : cpu_we;
                    addr_d     = pick_dma ? dma_addr  : cpu_addr;
                    wdata_d    = pick_dma ? dma_wdata : cpu_wdata;
                    size_d     = pick_dma ? dma_size  : cpu_size;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (cnt_q == 3'd0) begin
                    if (win_dma_q) begin
                        dma_rdata_d  = mem_dout2;
                        dma_rvalid_d = 1'b1;
                    end else begin
                        cpu_rdata_d  = mem_dout2;
                        cpu_rvalid_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight access
    always_ff @(posedge ARB_clk or negedge ARB_RST_n) begin
        if (!ARB_RST_n) begin
            state_q      <= IDLE;
            win_dma_q    <= 1'b0;
            last_dma_q   <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            size_q       <= 2'd0;
            cnt_q        <= 3'd0;
            cpu_rdata_q  <= 32'd0;
            dma_rdata_q  <= 32'd0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_dma_q    <= win_dma_d;
            last_dma_q   <= last_dma_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            cnt_q        <= cnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    // Strobes and grants exist only in ISSUE; address/data/size hold the latch
    always_comb begin
        cpu_gnt    = (state_q == ISSUE) && !win_dma_q;
        dma_gnt    = (state_q == ISSUE) &&  win_dma_q;
        mem_WE2    = (state_q == ISSUE) &&  we_q;
        mem_RDEN2  = (state_q == ISSUE) && !we_q;
        mem_addr2  = addr_q;
        mem_din2   = wdata_q;
        mem_size   = size_q;
        busy       = (state_q != IDLE);
        cpu_rdata  = cpu_rdata_q;
        dma_rdata  = dma_rdata_q;
        cpu_rvalid = cpu_rvalid_q;
        dma_rvalid = dma_rvalid_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed per-cycle vector table followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int RD_LAT = 3;
  localparam int NV     = 37;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic [1:0]  cpu_size = 0, dma_size = 0;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_RDEN2, mem_WE2;
  logic [31:0] mem_addr2, mem_din2, mem_dout2;
  logic [1:0]  mem_size;
  logic        busy;

  dmem_arbiter #(.RD_LAT(RD_LAT)) dut (
    .ARB_clk(clk), .ARB_RST_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_size(dma_size), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_RDEN2(mem_RDEN2), .mem_WE2(mem_WE2), .mem_addr2(mem_addr2), .mem_din2(mem_din2),
    .mem_size(mem_size), .mem_dout2(mem_dout2), .busy(busy)
  );

  // ---------------- memory behind port 2 ----------------
  // Data appears exactly RD_LAT cycles after the read strobe, junk otherwise.
  logic [31:0] phys_mem [16];
  logic [31:0] ref_mem  [16];
  logic [32:0] pipe     [RD_LAT];

  always @(posedge clk) begin
    if (mem_WE2) phys_mem[mem_addr2[5:2]] <= mem_din2;
    pipe[0] <= {mem_RDEN2, phys_mem[mem_addr2[5:2]]};
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_dout2 = pipe[RD_LAT-1][32] ? pipe[RD_LAT-1][31:0] : 32'hFFFF_0000;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One access at a time: it owns the port from its issue cycle up to m_end.
  // A write is done after its issue cycle; a read returns RD_LAT+1 cycles
  // after issue, which is also the first free cycle.
  int          cyc = 0;
  int          m_issue = -1;
  int          m_end = 0;
  bit          m_dma = 0, m_we = 1, m_last_dma = 1;
  logic [31:0] m_addr = 0, m_wdata = 0, m_cpu_rd = 0, m_dma_rd = 0;
  logic [1:0]  m_size = 0;

  always @(negedge clk) begin
    logic [6:0] e;
    bit in_issue, rv, bz, win;
    if (!rst_n) begin
      m_issue = -1; m_end = 0; m_dma = 0; m_we = 1; m_last_dma = 1;
      m_addr = 0; m_wdata = 0; m_size = 0; m_cpu_rd = 0; m_dma_rd = 0;
      e = 7'd0;
    end else begin
      in_issue = (m_issue >= 0) && (cyc == m_issue);
      rv       = (m_issue >= 0) && !m_we && (cyc == m_end);
      bz       = (m_issue >= 0) && (cyc >= m_issue) && (cyc < m_end);
      if (rv) begin
        if (m_dma) m_dma_rd = ref_mem[m_addr[5:2]];
        else       m_cpu_rd = ref_mem[m_addr[5:2]];
      end
      e = {in_issue && !m_dma, in_issue && m_dma, in_issue && !m_we, in_issue && m_we,
           bz, rv && !m_dma, rv && m_dma};
      if (in_issue && m_we) ref_mem[m_addr[5:2]] = m_wdata;
    end
    chk("ctrl", 64'({cpu_gnt, dma_gnt, mem_RDEN2, mem_WE2, busy, cpu_rvalid, dma_rvalid}), 64'(e));
    chk("mem_fields", 64'({mem_size, mem_addr2}), 64'({m_size, m_addr}));
    chk("mem_din2", 64'(mem_din2), 64'(m_wdata));
    chk("rdata", {cpu_rdata, dma_rdata}, {m_cpu_rd, m_dma_rd});
    chk("strobe_excl", 64'(mem_RDEN2 & mem_WE2), 64'd0);
    if (rst_n && cyc >= m_end && (cpu_req || dma_req)) begin
      win        = dma_req && (!cpu_req || !m_last_dma);
      m_dma      = win;
      m_last_dma = win;
      m_we       = win ? dma_we    : cpu_we;
      m_addr     = win ? dma_addr  : cpu_addr;
      m_wdata    = win ? dma_wdata : cpu_wdata;
      m_size     = win ? dma_size  : cpu_size;
      m_issue    = cyc + 1;
      m_end      = m_we ? cyc + 2 : cyc + RD_LAT + 2;
    end
    cyc++;
  end

  // ---------------- directed vector table ----------------
  // exp bits: {cpu_gnt, dma_gnt, mem_RDEN2, mem_WE2, busy, cpu_rvalid, dma_rvalid}
  typedef struct {
    logic       rst;
    logic       cr, cw, dr, dw;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(input logic rst, input logic cr, input logic cw,
                              input logic dr, input logic dw, input logic [6:0] exp);
    vec_t v;
    v.rst = rst; v.cr = cr; v.cw = cw; v.dr = dr; v.dw = dw; v.exp = exp;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit cp, dp, cg, dg;
    for (int i = 0; i < 16; i++) begin
      phys_mem[i] = $urandom;
      ref_mem[i]  = phys_mem[i];
    end
    for (int i = 0; i < RD_LAT; i++) pipe[i] = 33'd0;

    // CPU write then read back at 0x1004
    tbl[0]  = mk(1, 1, 1, 0, 0, 7'b0000000);
    tbl[1]  = mk(1, 1, 1, 0, 0, 7'b1001100);
    tbl[2]  = mk(1, 0, 0, 0, 0, 7'b0000000);
    tbl[3]  = mk(1, 1, 0, 0, 0, 7'b0000000);
    tbl[4]  = mk(1, 1, 0, 0, 0, 7'b1010100);
    tbl[5]  = mk(1, 0, 0, 0, 0, 7'b0000100);
    tbl[6]  = mk(1, 0, 0, 0, 0, 7'b0000100);
    tbl[7]  = mk(1, 0, 0, 0, 0, 7'b0000100);
    tbl[8]  = mk(1, 0, 0, 0, 0, 7'b0000010);
    // DMA read (req dropped in its ISSUE cycle); CPU write waits behind it
    tbl[9]  = mk(1, 0, 0, 1, 0, 7'b0000000);
    tbl[10] = mk(1, 0, 0, 0, 0, 7'b0110100);
    tbl[11] = mk(1, 1, 1, 0, 0, 7'b0000100);
    tbl[12] = mk(1, 1, 1, 0, 0, 7'b0000100);
    tbl[13] = mk(1, 1, 1, 0, 0, 7'b0000100);
    tbl[14] = mk(1, 1, 1, 0, 0, 7'b0000001);
    tbl[15] = mk(1, 1, 1, 0, 0, 7'b1001100);
    tbl[16] = mk(1, 0, 0, 0, 0, 7'b0000000);
    // Both read continuously: last grant was CPU, so DMA, CPU, DMA
    tbl[17] = mk(1, 1, 0, 1, 0, 7'b0000000);
    tbl[18] = mk(1, 1, 0, 1, 0, 7'b0110100);
    tbl[19] = mk(1, 1, 0, 1, 0, 7'b0000100);
    tbl[20] = mk(1, 1, 0, 1, 0, 7'b0000100);
    tbl[21] = mk(1, 1, 0, 1, 0, 7'b0000100);
    tbl[22] = mk(1, 1, 0, 1, 0, 7'b0000001);
    tbl[23] = mk(1, 1, 0, 1, 0, 7'b1010100);
    tbl[24] = mk(1, 1, 0, 1, 0, 7'b0000100);
    tbl[25] = mk(1, 1, 0, 1, 0, 7'b0000100);
    tbl[26] = mk(1, 1, 0, 1, 0, 7'b0000100);
    tbl[27] = mk(1, 1, 0, 1, 0, 7'b0000010);
    tbl[28] = mk(1, 1, 0, 1, 0, 7'b0110100);
    // Reset during WAIT_RD: no rvalid, then tie from reset grants CPU then DMA
    tbl[29] = mk(0, 1, 0, 1, 0, 7'b0000000);
    tbl[30] = mk(1, 1, 0, 1, 0, 7'b0000000);
    tbl[31] = mk(1, 1, 0, 1, 0, 7'b1010100);
    tbl[32] = mk(1, 1, 0, 1, 0, 7'b0000100);
    tbl[33] = mk(1, 1, 0, 1, 0, 7'b0000100);
    tbl[34] = mk(1, 1, 0, 1, 0, 7'b0000100);
    tbl[35] = mk(1, 1, 0, 1, 0, 7'b0000010);
    tbl[36] = mk(1, 0, 0, 0, 0, 7'b0110100);

    cpu_addr = 32'h0000_1004; cpu_wdata = 32'hDEAD_BEEF; cpu_size = 2'b10;
    dma_addr = 32'h0000_2008; dma_wdata = 32'h0BAD_F00D; dma_size = 2'b01;
    repeat (3) @(posedge clk);

    for (int r = 0; r < NV; r++) begin
      @(posedge clk); #1;
      rst_n = tbl[r].rst;
      cpu_req = tbl[r].cr; cpu_we = tbl[r].cw;
      dma_req = tbl[r].dr; dma_we = tbl[r].dw;
      if (!tbl[r].rst) begin
        #1;
        chk("async_rst_ctrl", 64'({cpu_gnt, dma_gnt, mem_RDEN2, mem_WE2, busy,
                                   cpu_rvalid, dma_rvalid}), 64'd0);
        chk("async_rst_rdata", {cpu_rdata, dma_rdata}, 64'd0);
        chk("async_rst_addr", 64'({mem_size, mem_addr2}), 64'd0);
      end
      @(negedge clk);
      chk($sformatf("row%0d", r),
          64'({cpu_gnt, dma_gnt, mem_RDEN2, mem_WE2, busy, cpu_rvalid, dma_rvalid}),
          64'(tbl[r].exp));
      if (r == 1) chk("wr_fields", 64'({mem_size, mem_addr2}), 64'({2'b10, 32'h0000_1004}));
      if (r == 1) chk("wr_data", 64'(mem_din2), 64'h0000_0000_DEAD_BEEF);
      if (r == 8) chk("cpu_rdata_ret", 64'(cpu_rdata), 64'h0000_0000_DEAD_BEEF);
      if (r == 9) chk("cpu_rdata_hold", 64'(cpu_rdata), 64'h0000_0000_DEAD_BEEF);
    end

    // Randomized traffic honouring hold-until-grant, with rare reset pulses
    cp = 0; dp = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cg = cpu_gnt; dg = dma_gnt;
      @(posedge clk); #1;
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 0; cp = 0; dp = 0; cpu_req = 0; dma_req = 0;
      end else begin
        rst_n = 1;
        if (cp && cg) begin cp = 0; cpu_req = 0; end
        if (dp && dg) begin dp = 0; dma_req = 0; end
        if (!cp && $urandom_range(0, 2) == 0) begin
          cp = 1; cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = $urandom; cpu_wdata = $urandom; cpu_size = 2'($urandom_range(0, 2));
        end
        if (!dp && $urandom_range(0, 2) == 0) begin
          dp = 1; dma_req = 1; dma_we = 1'($urandom_range(0, 1));
          dma_addr = $urandom; dma_wdata = $urandom; dma_size = 2'($urandom_range(0, 2));
        end
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
